// File: rtl/tb_mem_model_if.sv
// picorv32 native memory bus: request/response signals between core (master) and memory model.
interface tb_mem_model_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/tb_mem_model.sv
// Simulation memory for the picorv32 native bus: byte-strobed SRAM with fixed response latency,
// plus console, pass/fail and free-running timer registers exposed as ports.
module tb_mem_model #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned LATENCY      = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789,
  parameter logic [31:0] TIMER_ADDR   = 32'h3000_0000,
  parameter string       MEM_INIT     = ""
) (
  input  logic          clock,
  input  logic          resetn,
  tb_mem_model_if.slave mem,
  output logic          tests_passed,
  output logic          tests_failed,
  output logic          console_valid,
  output logic [7:0]    console_data,
  output logic          bus_error
);

  localparam int unsigned Words   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);
  localparam logic [31:0] BadData = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        passed_q, passed_d;
  logic        failed_q, failed_d;
  logic        con_valid_q, con_valid_d;
  logic [7:0]  con_data_q, con_data_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] sram_q [0:Words-1];

  logic                  enter_ready;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wstrb;
  logic                  is_write;
  logic                  sel_console;
  logic                  sel_pass;
  logic                  sel_timer;
  logic                  sel_sram;
  logic [ADDR_WIDTH-1:0] sram_idx;
  logic                  sram_we;

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      passed_q    <= 1'b0;
      failed_q    <= 1'b0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      passed_q    <= passed_d;
      failed_q    <= failed_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state: request capture, latency countdown and the READY entry strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    timer_d     = timer_q + 32'd1;
    enter_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem.mem_valid) begin
          addr_d  = mem.mem_addr;
          wdata_d = mem.mem_wdata;
          wstrb_d = mem.mem_wstrb;
          cnt_d   = CntInit;
          if (CntInit == 4'd0) begin
            state_d     = StReady;
            enter_ready = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = StReady;
          enter_ready = 1'b1;
        end
      end
      StReady: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY=1 the access completes on the capture edge, so use the live bus fields then.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = mem.mem_addr;
      acc_wdata = mem.mem_wdata;
      acc_wstrb = mem.mem_wstrb;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
  end

  always_comb begin
    is_write    = (acc_wstrb != 4'b0000);
    sel_console = (acc_addr == CONSOLE_ADDR);
    sel_pass    = (acc_addr == PASS_ADDR);
    sel_timer   = (acc_addr == TIMER_ADDR);
    sel_sram    = !(sel_console || sel_pass || sel_timer) &&
                  ((acc_addr >> (ADDR_WIDTH + 2)) == 32'd0);
    sram_idx    = acc_addr[ADDR_WIDTH+1:2];
  end

  // Access effects, all taken on the edge that enters READY.
  always_comb begin
    rdata_d     = rdata_q;
    passed_d    = passed_q;
    failed_d    = failed_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;
    bus_err_d   = bus_err_q;
    sram_we     = 1'b0;
    if (enter_ready) begin
      if (is_write) begin
        if (sel_sram) begin
          sram_we = resetn;
        end else if (sel_console) begin
          if (acc_wstrb[0]) begin
            con_valid_d = 1'b1;
            con_data_d  = acc_wdata[7:0];
          end
        end else if (sel_pass) begin
          if (acc_wdata == PASS_VALUE) begin
            passed_d = 1'b1;
          end else begin
            failed_d = 1'b1;
          end
        end else if (!sel_timer) begin
          bus_err_d = 1'b1;
        end
      end else begin
        if (sel_sram) begin
          rdata_d = sram_q[sram_idx];
        end else if (sel_timer) begin
          rdata_d = timer_q;
        end else if (sel_console || sel_pass) begin
          rdata_d = 32'd0;
        end else begin
          rdata_d   = BadData;
          bus_err_d = 1'b1;
        end
      end
    end
  end

  // SRAM is deliberately not reset.
  always_ff @(posedge clock) begin
    if (sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          sram_q[sram_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    mem.mem_ready = (state_q == StReady);
    mem.mem_rdata = rdata_q;
    tests_passed  = passed_q;
    tests_failed  = failed_q;
    console_valid = con_valid_q;
    console_data  = con_data_q;
    bus_error     = bus_err_q;
  end

endmodule

// File: tb/tb_tb_mem_model.sv
// Bench for tb_mem_model: one instance at LATENCY=1, one at LATENCY=4, scoreboarded responses.
module tb_tb_mem_model;

  localparam logic [31:0] ConsoleAddr = 32'h1000_0000;
  localparam logic [31:0] PassAddr    = 32'h2000_0000;
  localparam logic [31:0] TimerAddr   = 32'h3000_0000;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic resetn_l1;
  logic resetn_l4;

  logic       passed_l1, failed_l1, con_valid_l1, bus_err_l1;
  logic [7:0] con_data_l1;
  logic       passed_l4, failed_l4, con_valid_l4, bus_err_l4;
  logic [7:0] con_data_l4;

  tb_mem_model_if bus_l1 ();
  tb_mem_model_if bus_l4 ();

  tb_mem_model #(.LATENCY(1)) u_dut_l1 (
    .clock         (clock),
    .resetn        (resetn_l1),
    .mem           (bus_l1),
    .tests_passed  (passed_l1),
    .tests_failed  (failed_l1),
    .console_valid (con_valid_l1),
    .console_data  (con_data_l1),
    .bus_error     (bus_err_l1)
  );

  tb_mem_model #(.LATENCY(4)) u_dut_l4 (
    .clock         (clock),
    .resetn        (resetn_l4),
    .mem           (bus_l4),
    .tests_passed  (passed_l4),
    .tests_failed  (failed_l4),
    .console_valid (con_valid_l4),
    .console_data  (con_data_l4),
    .bus_error     (bus_err_l4)
  );

  always #5 clock = ~clock;

  int          cyc = 0;
  int          con_cnt = 0;
  logic [7:0]  con_last = '0;
  int          rdy_cnt_l4 = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          last_acc = 0;
  exp_t        sb_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (con_valid_l1) begin
      con_cnt  <= con_cnt + 1;
      con_last <= con_data_l1;
    end
    if (bus_l4.mem_ready) rdy_cnt_l4 <= rdy_cnt_l4 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; optionally disturbs the bus fields while the request is in flight.
  task automatic req(input string tag, input bit use_l4, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input bit chk,
                     input logic [31:0] exp, input bit swap, input int start,
                     output logic [31:0] rd);
    exp_t e;
    int   k;
    bit   seen;
    int   lat;
    lat = use_l4 ? 4 : 1;
    while (cyc < start) @(negedge clock);
    e.chk  = chk;
    e.data = exp;
    sb_q.push_back(e);
    if (use_l4) begin
      bus_l4.mem_valid = 1'b1;
      bus_l4.mem_addr  = addr;
      bus_l4.mem_wdata = wdata;
      bus_l4.mem_wstrb = strb;
    end else begin
      bus_l1.mem_valid = 1'b1;
      bus_l1.mem_addr  = addr;
      bus_l1.mem_wdata = wdata;
      bus_l1.mem_wstrb = strb;
    end
    @(posedge clock);
    last_acc = cyc;
    seen = 1'b0;
    k    = 0;
    rd   = '0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        if (use_l4) begin
          bus_l4.mem_valid = 1'b0;
          if (swap) begin
            bus_l4.mem_addr  = addr ^ 32'h4;
            bus_l4.mem_wdata = ~wdata;
            bus_l4.mem_wstrb = 4'b1111;
          end
        end else begin
          bus_l1.mem_valid = 1'b0;
        end
      end
      if (use_l4 ? bus_l4.mem_ready : bus_l1.mem_ready) seen = 1'b1;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check_eq({tag, "_ready_timeout"}, 32'(k), 32'(lat));
    end else begin
      check_eq({tag, "_latency"}, 32'(k), 32'(lat));
      rd = use_l4 ? bus_l4.mem_rdata : bus_l1.mem_rdata;
      if (e.chk) check_eq({tag, "_rdata"}, rd, e.data);
      @(negedge clock);
      check_eq({tag, "_ready_width"},
               {31'd0, (use_l4 ? bus_l4.mem_ready : bus_l1.mem_ready)}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t, limit 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] t1;
    logic [31:0] t2;
    int          rdy_before;

    resetn_l1 = 1'b0;
    resetn_l4 = 1'b0;
    bus_l1.mem_valid = 1'b0; bus_l1.mem_addr = '0; bus_l1.mem_wdata = '0; bus_l1.mem_wstrb = '0;
    bus_l4.mem_valid = 1'b0; bus_l4.mem_addr = '0; bus_l4.mem_wdata = '0; bus_l4.mem_wstrb = '0;
    repeat (3) @(negedge clock);

    check_eq("rst_ready", {31'd0, bus_l1.mem_ready}, 32'd0);
    check_eq("rst_rdata", bus_l1.mem_rdata, 32'd0);
    check_eq("rst_passed", {31'd0, passed_l1}, 32'd0);
    check_eq("rst_failed", {31'd0, failed_l1}, 32'd0);
    check_eq("rst_con_valid", {31'd0, con_valid_l1}, 32'd0);
    check_eq("rst_con_data", {24'd0, con_data_l1}, 32'd0);
    check_eq("rst_bus_err", {31'd0, bus_err_l1}, 32'd0);
    resetn_l1 = 1'b1;
    resetn_l4 = 1'b1;
    @(negedge clock);

    // Basic write/read round trip.
    req("wr40", 1'b0, 32'h40, 32'hA5A5_5A5A, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    req("rd40", 1'b0, 32'h40, 32'h0, 4'b0000, 1'b1, 32'hA5A5_5A5A, 1'b0, -1, rd);

    // Byte strobes.
    req("fill80", 1'b0, 32'h80, 32'hFFFF_FFFF, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    req("strb80", 1'b0, 32'h80, 32'h1122_3344, 4'b0101, 1'b0, '0, 1'b0, -1, rd);
    req("rd80", 1'b0, 32'h80, 32'h0, 4'b0000, 1'b1, 32'hFF22_FF44, 1'b0, -1, rd);

    // LATENCY=4 with the address changed mid-flight.
    req("l4wr100", 1'b1, 32'h100, 32'hCAFE_0001, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    req("l4wr104", 1'b1, 32'h104, 32'h0BAD_F00D, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    req("l4rd100", 1'b1, 32'h100, 32'h0, 4'b0000, 1'b1, 32'hCAFE_0001, 1'b1, -1, rd);
    req("l4rd104", 1'b1, 32'h104, 32'h0, 4'b0000, 1'b1, 32'h0BAD_F00D, 1'b0, -1, rd);

    // MMIO.
    req("con_wr", 1'b0, ConsoleAddr, 32'h48, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    check_eq("con_pulses", 32'(con_cnt), 32'd1);
    check_eq("con_data", {24'd0, con_last}, 32'h48);
    req("con_nostrb", 1'b0, ConsoleAddr, 32'h49, 4'b0010, 1'b0, '0, 1'b0, -1, rd);
    check_eq("con_dropped", 32'(con_cnt), 32'd1);
    req("con_rd", 1'b0, ConsoleAddr, 32'h0, 4'b0000, 1'b1, 32'd0, 1'b0, -1, rd);
    req("pass_wr", 1'b0, PassAddr, 32'd123456789, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    check_eq("passed_set", {31'd0, passed_l1}, 32'd1);
    check_eq("failed_clear", {31'd0, failed_l1}, 32'd0);
    req("fail_wr", 1'b0, PassAddr, 32'd7, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    check_eq("failed_set", {31'd0, failed_l1}, 32'd1);
    check_eq("passed_sticky", {31'd0, passed_l1}, 32'd1);

    // Timer spacing and unmapped access.
    req("tmr1", 1'b0, TimerAddr, 32'h0, 4'b0000, 1'b0, '0, 1'b0, -1, rd);
    t1 = rd;
    req("tmr2", 1'b0, TimerAddr, 32'h0, 4'b0000, 1'b0, '0, 1'b0, last_acc + 10, rd);
    t2 = rd;
    check_eq("timer_delta", t2 - t1, 32'd10);
    check_eq("bus_err_clear", {31'd0, bus_err_l1}, 32'd0);
    req("unmapped", 1'b0, 32'h4000_0000, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0, -1, rd);
    check_eq("bus_err_set", {31'd0, bus_err_l1}, 32'd1);

    // Reset while a write is waiting.
    req("l4pass", 1'b1, PassAddr, 32'd123456789, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    req("l4unmapped", 1'b1, 32'h4000_0000, 32'h0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0, -1, rd);
    req("l4wr200", 1'b1, 32'h200, 32'h1111_1111, 4'b1111, 1'b0, '0, 1'b0, -1, rd);
    check_eq("l4_pre_passed", {31'd0, passed_l4}, 32'd1);
    bus_l4.mem_valid = 1'b1;
    bus_l4.mem_addr  = 32'h200;
    bus_l4.mem_wdata = 32'h2222_2222;
    bus_l4.mem_wstrb = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    bus_l4.mem_valid = 1'b0;
    resetn_l4 = 1'b0;
    rdy_before = rdy_cnt_l4;
    repeat (2) @(negedge clock);
    resetn_l4 = 1'b1;
    repeat (6) @(negedge clock);
    check_eq("rst_no_ready", 32'(rdy_cnt_l4), 32'(rdy_before));
    check_eq("rst_l4_passed", {31'd0, passed_l4}, 32'd0);
    check_eq("rst_l4_failed", {31'd0, failed_l4}, 32'd0);
    check_eq("rst_l4_bus_err", {31'd0, bus_err_l4}, 32'd0);
    check_eq("rst_l4_rdata", bus_l4.mem_rdata, 32'd0);
    req("l4rd200", 1'b1, 32'h200, 32'h0, 4'b0000, 1'b1, 32'h1111_1111, 1'b0, -1, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
